bfly10_pair_buffer: RTL and testbench

Pairing buffer between the CBFP normalisation stage (step0_2 output, 16 lanes × 11-bit complex per beat) and the first butterfly of FFT module 1 (bfly10). It stores the first half of each butterfly block and, during the second half, emits each stored beat together with the beat that arrives DIST_BEATS later. The butterfly therefore receives both operands `x[n]` and `x[n+D]` on the same cycle. It also tracks block and frame position so downstream twiddle logic can index from `blk_idx`.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/bfly10_pair_buffer_if.sv | 44 ++++
 rtl/pair_delay_line.sv | 39 +++
 rtl/bfly10_pair_buffer.sv | 155 +++++++++++++++
 tb/tb_bfly10_pair_buffer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg
// Shared types and constants for the FFT datapath.
//   DATA_WIDTH : signed width of one real or imaginary sample
//   LANES      : samples carried per beat
//   N_POINT    : FFT frame length in samples
//   sample_t   : one signed lane value
//   lane_arr_t : one beat's worth of real (or imag) parts, lane 0 first
//   cplx_t     : packed complex sample {re, im}
//   cplx_vec_t : packed beat of LANES complex samples
package fft_pkg;

  localparam int unsigned DATA_WIDTH = 11;
  localparam int unsigned LANES      = 16;
  localparam int unsigned N_POINT    = 512;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef sample_t lane_arr_t [0:LANES-1];

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [LANES-1:0] cplx_vec_t;

  // Index width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Butterfly blocks per frame for a given butterfly distance in beats.
  function automatic int unsigned n_blocks(input int unsigned dist_beats);
    return N_POINT / (LANES * 2 * dist_beats);
  endfunction

endpackage

// File: rtl/bfly10_pair_buffer_if.sv
// bfly10_pair_buffer_if
// Input beat stream from the CBFP stage and paired output stream to bfly10.
//   din_valid, din_real, din_imag      : input beat (no backpressure)
//   valid_out                          : pair beat valid
//   a_real, a_imag                     : earlier operand x[n]
//   b_real, b_imag                     : later operand x[n+D]
//   blk_idx, pair_idx, frame_last      : position of the current pair
// Modports: master drives the input beat and observes the pairs,
//           slave is the pairing buffer itself.
interface bfly10_pair_buffer_if
  import fft_pkg::*;
#(
  parameter int unsigned DIST_BEATS = 4
) ();

  localparam int unsigned BLK_W  = idx_w(n_blocks(DIST_BEATS));
  localparam int unsigned PAIR_W = idx_w(DIST_BEATS);

  logic              din_valid;
  lane_arr_t         din_real;
  lane_arr_t         din_imag;

  logic              valid_out;
  lane_arr_t         a_real;
  lane_arr_t         a_imag;
  lane_arr_t         b_real;
  lane_arr_t         b_imag;
  logic [BLK_W-1:0]  blk_idx;
  logic [PAIR_W-1:0] pair_idx;
  logic              frame_last;

  modport master (
    output din_valid, din_real, din_imag,
    input  valid_out, a_real, a_imag, b_real, b_imag,
    input  blk_idx, pair_idx, frame_last
  );

  modport slave (
    input  din_valid, din_real, din_imag,
    output valid_out, a_real, a_imag, b_real, b_imag,
    output blk_idx, pair_idx, frame_last
  );

endinterface

// File: rtl/pair_delay_line.sv
// pair_delay_line
// DEPTH-slot beat store holding the first half of a butterfly block.
//   clk, rstn  : clock, asynchronous active-low reset (clears all slots)
//   wr_en_i    : write wr_data_i into slot wr_idx_i
//   wr_idx_i   : write slot index
//   wr_data_i  : beat to store
//   rd_idx_i   : read slot index
//   rd_data_o  : contents of slot rd_idx_i (combinational read)
// Writes and reads never target the same beat, so no write-through path.
module pair_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  cplx_vec_t        wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output cplx_vec_t        rd_data_o
);

  cplx_vec_t slot_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      slot_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = slot_q[rd_idx_i];

endmodule

// File: rtl/bfly10_pair_buffer.sv
// bfly10_pair_buffer
// Pairs x[n] with x[n+D] (D = DIST_BEATS*LANES samples) for the first
// butterfly of FFT module 1. The first DIST_BEATS beats of every block are
// stored; each of the next DIST_BEATS beats is emitted one clock later
// alongside its stored partner. Position counters advance on input beats
// only, so gaps in din_valid do not disturb the pairing.
//   clk        : system clock
//   rstn       : asynchronous active-low reset
//   bus        : slave side of bfly10_pair_buffer_if (input beats in,
//                pair beats with blk_idx/pair_idx/frame_last out)
module bfly10_pair_buffer
  import fft_pkg::*;
#(
  parameter int unsigned DIST_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  bfly10_pair_buffer_if.slave   bus
);

  localparam int unsigned BLK_BEATS = 2 * DIST_BEATS;
  localparam int unsigned N_BLOCKS  = n_blocks(DIST_BEATS);
  localparam int unsigned BEAT_W    = idx_w(BLK_BEATS);
  localparam int unsigned BLK_W     = idx_w(N_BLOCKS);
  localparam int unsigned PAIR_W    = idx_w(DIST_BEATS);

  if ((DIST_BEATS == 0) || ((DIST_BEATS & (DIST_BEATS - 1)) != 0)) begin : g_bad_dist
    $error("DIST_BEATS must be a non-zero power of 2");
  end
  if ((N_POINT % (LANES * BLK_BEATS)) != 0 || N_BLOCKS == 0) begin : g_bad_frame
    $error("N_POINT must divide evenly into butterfly blocks");
  end

  typedef enum logic {
    PH_FILL,
    PH_PAIR
  } phase_e;

  // Position counters
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [BLK_W-1:0]  blk_cnt_q,  blk_cnt_d;

  // Output registers
  logic              valid_q,      valid_d;
  logic              frame_last_q, frame_last_d;
  logic [BLK_W-1:0]  blk_idx_q,    blk_idx_d;
  logic [PAIR_W-1:0] pair_idx_q,   pair_idx_d;
  cplx_vec_t         a_q,          a_d;
  cplx_vec_t         b_q,          b_d;

  phase_e            phase;
  logic              wr_en;
  logic [PAIR_W-1:0] slot_idx;
  cplx_vec_t         din_vec;
  cplx_vec_t         stored_vec;

  always_comb begin
    din_vec = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      din_vec[k].re = bus.din_real[k];
      din_vec[k].im = bus.din_imag[k];
    end
  end

  // Fill writes slot beat_cnt, pair reads slot beat_cnt-DIST_BEATS; since
  // DIST_BEATS is a power of 2 both reduce to the low PAIR_W bits.
  always_comb begin
    phase    = (beat_cnt_q < BEAT_W'(DIST_BEATS)) ? PH_FILL : PH_PAIR;
    slot_idx = PAIR_W'(beat_cnt_q - BEAT_W'(DIST_BEATS));
    if (phase == PH_FILL) begin
      slot_idx = PAIR_W'(beat_cnt_q);
    end
    wr_en    = bus.din_valid && (phase == PH_FILL);
  end

  pair_delay_line #(
    .DEPTH (DIST_BEATS),
    .IDX_W (PAIR_W)
  ) u_delay (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (wr_en),
    .wr_idx_i  (slot_idx),
    .wr_data_i (din_vec),
    .rd_idx_i  (slot_idx),
    .rd_data_o (stored_vec)
  );

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    valid_d      = 1'b0;
    frame_last_d = 1'b0;
    blk_idx_d    = blk_idx_q;
    pair_idx_d   = pair_idx_q;
    a_d          = a_q;
    b_d          = b_q;

    if (bus.din_valid) begin
      if (beat_cnt_q == BEAT_W'(BLK_BEATS - 1)) begin
        beat_cnt_d = '0;
        blk_cnt_d  = (blk_cnt_q == BLK_W'(N_BLOCKS - 1)) ? '0 : blk_cnt_q + BLK_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end

      if (phase == PH_PAIR) begin
        valid_d      = 1'b1;
        a_d          = stored_vec;
        b_d          = din_vec;
        pair_idx_d   = slot_idx;
        blk_idx_d    = blk_cnt_q;
        frame_last_d = (beat_cnt_q == BEAT_W'(BLK_BEATS - 1)) &&
                       (blk_cnt_q == BLK_W'(N_BLOCKS - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt_q   <= '0;
      blk_cnt_q    <= '0;
      valid_q      <= 1'b0;
      frame_last_q <= 1'b0;
      blk_idx_q    <= '0;
      pair_idx_q   <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      valid_q      <= valid_d;
      frame_last_q <= frame_last_d;
      blk_idx_q    <= blk_idx_d;
      pair_idx_q   <= pair_idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      bus.a_real[k] = a_q[k].re;
      bus.a_imag[k] = a_q[k].im;
      bus.b_real[k] = b_q[k].re;
      bus.b_imag[k] = b_q[k].im;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.frame_last = frame_last_q;
  assign bus.blk_idx    = blk_idx_q;
  assign bus.pair_idx   = pair_idx_q;

endmodule

// File: tb/tb_bfly10_pair_buffer.sv
module tb_bfly10_pair_buffer;
  import fft_pkg::*;

  logic clk;
  logic rstn;

  int n_checks;
  int n_fail;
  int obs_pairs;
  int obs_fl;
  logic [31:0] last_a0;
  logic [31:0] last_b0;

  bfly10_pair_buffer_if #(.DIST_BEATS(4)) bus ();

  bfly10_pair_buffer #(.DIST_BEATS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ramp re=16*dt+k, im=-(16*dt+k)
  // mode 1: extremes, -1024/+1023 alternating by lane and by half-block
  function automatic sample_t dat(input int mode, input int dt, input int k, input bit im);
    int v;
    if (mode == 0) begin
      v = 16 * dt + k;
      if (im) v = -v;
    end else begin
      v = (((k + dt / 4) % 2) == 0) ? -1024 : 1023;
      if (im) v = (v == -1024) ? 1023 : -1024;
    end
    return DATA_WIDTH'(v);
  endfunction

  // One clock: drive an input beat (or an idle cycle with junk data), then
  // check the registered outputs produced by it. t = position in frame,
  // dt = data index.
  task automatic beat(input logic v, input int t, input int dt, input int mode);
    bit exp_v;
    bit exp_fl;
    @(negedge clk);
    bus.din_valid = v;
    for (int k = 0; k < 16; k++) begin
      bus.din_real[k] = v ? dat(mode, dt, k, 1'b0) : DATA_WIDTH'($urandom);
      bus.din_imag[k] = v ? dat(mode, dt, k, 1'b1) : DATA_WIDTH'($urandom);
    end
    @(posedge clk);
    #1;
    exp_v  = v && ((t % 8) >= 4);
    exp_fl = exp_v && ((t % 32) == 31);
    chk("valid_out", {31'd0, bus.valid_out}, {31'd0, exp_v});
    chk("frame_last", {31'd0, bus.frame_last}, {31'd0, exp_fl});
    if (bus.valid_out)  obs_pairs++;
    if (bus.frame_last) obs_fl++;
    if (exp_v) begin
      for (int k = 0; k < 16; k++) begin
        chk("a_real", bus.a_real[k], dat(mode, dt - 4, k, 1'b0));
        chk("a_imag", bus.a_imag[k], dat(mode, dt - 4, k, 1'b1));
        chk("b_real", bus.b_real[k], dat(mode, dt, k, 1'b0));
        chk("b_imag", bus.b_imag[k], dat(mode, dt, k, 1'b1));
      end
      chk("blk_idx", 32'(bus.blk_idx), 32'((t / 8) % 4));
      chk("pair_idx", 32'(bus.pair_idx), 32'(t % 4));
      last_a0 = dat(mode, dt - 4, 0, 1'b0);
      last_b0 = dat(mode, dt, 0, 1'b0);
    end else begin
      chk("a_hold", bus.a_real[0], last_a0);
      chk("b_hold", bus.b_real[0], last_b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    chk({tag, "_frame_last"}, {31'd0, bus.frame_last}, 32'd0);
    chk({tag, "_blk_idx"}, 32'(bus.blk_idx), 32'd0);
    chk({tag, "_pair_idx"}, 32'(bus.pair_idx), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_a_real"}, bus.a_real[k], 32'd0);
      chk({tag, "_a_imag"}, bus.a_imag[k], 32'd0);
      chk({tag, "_b_real"}, bus.b_real[k], 32'd0);
      chk({tag, "_b_imag"}, bus.b_imag[k], 32'd0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    obs_pairs = 0;
    obs_fl    = 0;
    last_a0   = '0;
    last_b0   = '0;
    rstn      = 1'b0;
    bus.din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus.din_real[k] = '0;
      bus.din_imag[k] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Idle: nothing emitted, nothing disturbed
    for (int i = 0; i < 100; i++) beat(1'b0, 0, 0, 0);

    // Ramp, one full frame; counters must still start at beat 0 / block 0
    obs_pairs = 0;
    obs_fl    = 0;
    for (int t = 0; t < 32; t++) beat(1'b1, t, t, 0);
    chk("ramp_pairs", 32'(obs_pairs), 32'd16);
    chk("ramp_frame_last", 32'(obs_fl), 32'd1);

    // Gapped: valid toggles 1/0
    obs_pairs = 0;
    for (int t = 0; t < 32; t++) begin
      beat(1'b1, t, t, 0);
      beat(1'b0, t, t, 0);
    end
    chk("gap_pairs", 32'(obs_pairs), 32'd16);

    // Extremes
    for (int t = 0; t < 32; t++) beat(1'b1, t, t, 1);

    // Back-to-back frames
    obs_pairs = 0;
    obs_fl    = 0;
    for (int t = 0; t < 64; t++) beat(1'b1, t, t, 0);
    chk("b2b_pairs", 32'(obs_pairs), 32'd32);
    chk("b2b_frame_last", 32'(obs_fl), 32'd2);

    // Reset mid-block after beat 6
    for (int t = 0; t < 7; t++) beat(1'b1, t, t, 0);
    #2;
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    last_a0 = '0;
    last_b0 = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 0; t < 8; t++) beat(1'b1, t, t + 40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
